// File: rtl/rc4_pkg.sv
// Shared types and constants for the decrypted-message UART transmitter.
package rc4_pkg;

  localparam int MSG_LEN_DEFAULT = 32;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Message sequencer states: RAM fetch, data latch, frame in flight, done pulse.
  typedef enum logic [2:0] {
    T_IDLE,
    T_FETCH,
    T_READ,
    T_SEND,
    T_DONE
  } msg_state_e;

  // Serializer states for one 8N1 frame.
  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } ser_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 serializer: load latches a byte and starts a frame immediately, even
// in the final stop cycle of the previous frame, so frames can run back to back.
// frame_done_o is high in the last cycle of the stop bit.
module uart_tx_byte
  import rc4_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       frame_done_o
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  ser_state_e  state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        tx_q, tx_d;
  logic        bit_end;

  assign bit_end = (baud_q == BAUD_LAST);
  assign tx_o    = tx_q;

  // Next-state logic: walk start, eight data bits LSB first, stop.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
    state_d      = state_q;
    baud_d       = baud_q + 16'd1;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    tx_d         = tx_q;
    frame_done_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
      end
      S_START: if (bit_end) begin
        state_d = S_DATA;
        baud_d  = '0;
        tx_d    = shreg_q[0];
      end
      S_DATA: if (bit_end) begin
        baud_d  = '0;
        bit_d   = bit_q + 3'd1;
        shreg_d = shreg_q >> 1;
        if (bit_q == 3'd7) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end else begin
          tx_d = shreg_q[1];
        end
      end
      S_STOP: if (bit_end) begin
        state_d      = S_IDLE;
        baud_d       = '0;
        frame_done_o = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (load_i) begin
      state_d = S_START;
      baud_d  = '0;
      bit_d   = '0;
      shreg_d = data_i;
      tx_d    = 1'b0;
    end
  end

  // Serializer registers with synchronous active-low reset; the line idles high.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so all flops update together from pre-edge values.
    if (!reset_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      // NOTE: the data shift register is reset too, so nothing downstream ever sees X after reset.
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/rc4_msg_uart_tx.sv
// Streams the decrypted-message RAM out as 8N1 UART. Each byte is one FETCH
// cycle (address out), one READ cycle (RAM data latched into the serializer),
// then a full frame. Optional CR/LF trailer: define RC4_MSG_TX_CRLF_EN.
module rc4_msg_uart_tx
  import rc4_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int MSG_LEN      = MSG_LEN_DEFAULT,
  parameter int ADDR_W       = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [7:0]        mem_q,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] byte_idx
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN - 1);

  msg_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              load;
  logic [7:0]        load_data;
  logic              frame_done;
`ifdef RC4_MSG_TX_CRLF_EN
  // 0: message bytes, 1: CR frame in flight, 2: LF frame in flight.
  logic [1:0]        trail_q, trail_d;
`endif

  // The address is the byte index itself, so it stays put for the whole byte.
  assign mem_address = idx_q;
  assign byte_idx    = idx_q;
  assign busy        = (state_q != T_IDLE);
  assign done        = (state_q == T_DONE);

  // Sequencer: fetch each byte, hand it to the serializer, step on frame end.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    load      = 1'b0;
    load_data = mem_q;
`ifdef RC4_MSG_TX_CRLF_EN
    trail_d   = trail_q;
`endif
    unique case (state_q)
      T_IDLE: if (start) begin
        state_d = T_FETCH;
        idx_d   = '0;
`ifdef RC4_MSG_TX_CRLF_EN
        trail_d = 2'd0;
`endif
      end
      T_FETCH: state_d = T_READ;
      T_READ: begin
        load    = 1'b1;
        state_d = T_SEND;
      end
      T_SEND: if (frame_done) begin
`ifdef RC4_MSG_TX_CRLF_EN
        if (trail_q == 2'd1) begin
          load      = 1'b1;
          load_data = ASCII_LF;
          trail_d   = 2'd2;
        end else if (trail_q == 2'd2) begin
          state_d = T_DONE;
          trail_d = 2'd0;
        end else if (idx_q == LAST_IDX) begin
          load      = 1'b1;
          load_data = ASCII_CR;
          trail_d   = 2'd1;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = T_FETCH;
        end
`else
        if (idx_q == LAST_IDX) begin
          state_d = T_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = T_FETCH;
        end
`endif
      end
      T_DONE:  state_d = T_IDLE;
      default: state_d = T_IDLE;
    endcase
  end

  // Sequencer registers; reset aborts any message in progress.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= T_IDLE;
      idx_q   <= '0;
`ifdef RC4_MSG_TX_CRLF_EN
      trail_q <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
`ifdef RC4_MSG_TX_CRLF_EN
      trail_q <= trail_d;
`endif
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_i      (load),
    .data_i      (load_data),
    .tx_o        (tx),
    .frame_done_o(frame_done)
  );

endmodule

// File: tb/tb_rc4_msg_uart_tx.sv
// Bench for rc4_msg_uart_tx: a line decoder turns tx back into bytes and
// compares them with a queue of expected bytes; a done monitor compares each
// done pulse with a queue of expected cycle numbers.
module tb_rc4_msg_uart_tx;

  localparam int CPB    = 4;
  localparam int ADDR_W = 5;
`ifdef RC4_MSG_TX_CRLF_EN
  localparam int MSG_LEN = 2;
  localparam int N_TRAIL = 2;
`else
  localparam int MSG_LEN = 32;
  localparam int N_TRAIL = 0;
`endif
  localparam int FRAME     = 10 * CPB;
  localparam int TOTAL     = MSG_LEN * (2 + FRAME) + N_TRAIL * FRAME + 1;
  localparam int ABORT_IDX = (MSG_LEN > 3) ? 3 : MSG_LEN - 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] mem_address;
  logic [7:0]        mem_q;
  logic              tx;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] byte_idx;

  logic [7:0]  ram [32];
  logic [7:0]  exp_bytes [$];
  int          exp_done [$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          max_addr = 0;
  logic [FRAME-1:0] mon_s;
  bit          mon_abort;

  rc4_msg_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .MSG_LEN     (MSG_LEN),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .mem_address(mem_address),
    .mem_q      (mem_q),
    .tx         (tx),
    .busy       (busy),
    .done       (done),
    .byte_idx   (byte_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM, one cycle of read latency.
  always @(posedge clk) mem_q <= ram[mem_address];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Decode one captured frame: every bit level must be steady for CPB samples.
  task automatic check_frame(input logic [FRAME-1:0] s);
    logic [7:0] data;
    logic       lvl;
    bit         framed;
    framed = 1'b1;
    data   = '0;
    for (int b = 0; b < 10; b++) begin
      lvl = s[b*CPB];
      for (int k = 1; k < CPB; k++)
        if (s[b*CPB+k] !== lvl) framed = 1'b0;
      if (b >= 1 && b <= 8) data[b-1] = lvl;
    end
    if (s[0] !== 1'b0 || s[9*CPB] !== 1'b1) framed = 1'b0;
    check("frame_shape", {31'd0, framed}, 32'd1);
    if (exp_bytes.size() == 0)
      check("rx_without_expect", 32'(exp_bytes.size()), 32'd1);
    else
      check("rx_byte", {24'd0, data}, {24'd0, exp_bytes.pop_front()});
  endtask

  // Line decoder: frame starts on the first low sample while out of reset.
  initial begin : line_mon
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && tx === 1'b0) begin
        mon_s     = '0;
        mon_s[0]  = tx;
        mon_abort = 1'b0;
        for (int i = 1; i < FRAME; i++) begin
          @(negedge clk);
          if (reset_n !== 1'b1) begin
            mon_abort = 1'b1;
            break;
          end
          mon_s[i] = tx;
        end
        if (!mon_abort) check_frame(mon_s);
      end
    end
  end

  // Done monitor and address-range tracker.
  initial begin : done_mon
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && busy === 1'b1 && int'(mem_address) > max_addr)
        max_addr = int'(mem_address);
      if (reset_n === 1'b1 && done === 1'b1) begin
        if (exp_done.size() == 0) check("done_unexpected", {31'd0, done}, 32'd0);
        else                      check("done_cycle", cyc, exp_done.pop_front());
      end
    end
  end

  task automatic push_expected();
    for (int i = 0; i < MSG_LEN; i++) exp_bytes.push_back(ram[i]);
    if (N_TRAIL > 0) begin
      exp_bytes.push_back(8'h0D);
      exp_bytes.push_back(8'h0A);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++) ram[i] = 8'($urandom_range(0, 255));
  endtask

  // One full message; optionally checks raw line levels of byte 0 and
  // re-pulses start while busy once byte_idx reaches restart_at.
  task automatic run_msg(input bit watch_bits, input int restart_at);
    logic [ADDR_W-1:0] prev, nxt;
    logic [CPB-1:0]    grp;
    logic [9:0]        lv;
    bit                pulsed;
    pulsed = 1'b0;
    push_expected();
    @(negedge clk);
    check("idle_before_start", {31'd0, busy}, 32'd0);
    start = 1'b1;
    exp_done.push_back(cyc + TOTAL);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("fetch_addr", 32'(mem_address), 32'd0);
    check("fetch_idx", 32'(byte_idx), 32'd0);
    if (watch_bits) begin
      lv = {1'b1, ram[0], 1'b0};
      @(negedge clk);
      for (int b = 0; b < 10; b++) begin
        for (int k = 0; k < CPB; k++) begin
          @(negedge clk);
          grp[k] = tx;
        end
        check("bit_level", 32'(grp), 32'({CPB{lv[b]}}));
      end
    end
    prev = '0;
    for (int i = 0; i < TOTAL + 20 && exp_done.size() != 0; i++) begin
      @(negedge clk);
      if (start) start = 1'b0;
      else if (restart_at >= 0 && !pulsed && int'(byte_idx) == restart_at) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      if (byte_idx !== prev) begin
        nxt = prev + 1'b1;
        check("byte_idx_step", 32'(byte_idx), 32'(nxt));
        prev = byte_idx;
      end
    end
    start = 1'b0;
    check("done_seen", 32'(exp_done.size()), 32'd0);
    repeat (3) @(negedge clk);
    check("bytes_left", 32'(exp_bytes.size()), 32'd0);
    check("idle_after_done", {31'd0, busy}, 32'd0);
    check("tx_idle_after_done", {31'd0, tx}, 32'd1);
  endtask

  // Start a message and pull reset during the data bits of byte ABORT_IDX.
  task automatic abort_run();
    push_expected();
    @(negedge clk);
    start = 1'b1;
    exp_done.push_back(cyc + TOTAL);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < TOTAL && int'(byte_idx) != ABORT_IDX; i++) @(negedge clk);
    check("reached_abort_byte", 32'(byte_idx), 32'(ABORT_IDX));
    repeat (12) @(negedge clk);
    check("tx_low_mid_data", {31'd0, tx}, 32'd0);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_tx", {31'd0, tx}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_addr", 32'(mem_address), 32'd0);
    exp_bytes.delete();
    exp_done.delete();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin : stim
    reset_n = 1'b0;
    start   = 1'b1;
    for (int i = 0; i < 32; i++) ram[i] = 8'(8'h61 + i);
    repeat (3) begin
      @(negedge clk);
      check("reset_tx", {31'd0, tx}, 32'd1);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_addr", 32'(mem_address), 32'd0);
    end
    start   = 1'b0;
    reset_n = 1'b1;

    run_msg(1'b0, -1);

    fill_random();
    ram[0] = 8'hA5;
    run_msg(1'b1, -1);

    fill_random();
    ram[1] = 8'h00;
    ram[2] = 8'hFF;
    run_msg(1'b0, (MSG_LEN > 5) ? 5 : 0);

    fill_random();
    ram[ABORT_IDX] = 8'h00;
    abort_run();
    run_msg(1'b0, -1);

    check("max_mem_address", 32'(max_addr), 32'(MSG_LEN - 1));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rc4_msg_uart_tx.md
Name: rc4_msg_uart_tx

Overview:
- Reads the 32-byte decrypted-message RAM written by the RC4 decrypt path and streams it out of the board as 8N1 UART serial.
- It is the reader/transmit end of the decrypted-message memory interface.
- Triggered once the brute-force core reports a correct key. It owns the RAM read address while busy; the top-level mux grants it the port when busy=1.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200 baud); legal range 2..65535.
- MSG_LEN, 32, number of message bytes sent; legal range 1..32.
- ADDR_W, 5, decrypted-message RAM address width.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  level/pulse request; sampled only in IDLE.
- mem_address  out  ADDR_W  decrypted-message RAM read address.
- mem_q  in  8  RAM read data, valid one cycle after mem_address is presented (synchronous RAM).
- tx  out  1  UART serial line, idle high.
- busy  out  1  high from the cycle after start is accepted until DONE exits.
- done  out  1  one-cycle pulse when the last stop bit completes.
- byte_idx  out  ADDR_W  index of the byte currently being sent (for HEX/LED debug).

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE, tx=1, busy=0, done=0, mem_address=0, byte_idx=0, bit/baud counters=0.
- Reset mid-frame aborts immediately: tx=1 from the next edge, and no partial stop bit is emitted.
- FSM states: IDLE, FETCH, READ, START, DATA, STOP, DONE.
- IDLE:
  - tx=1, busy=0.
  - If start=1, go to FETCH with byte_idx=0 and mem_address=0.
- FETCH: 1 cycle; mem_address=byte_idx.
- READ: 1 cycle; at the end of the cycle, mem_q is latched into an 8-bit shift register.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA:
  - 8 bits, LSB first, each held for CLKS_PER_BIT cycles.
  - Shift right after each bit; a 3-bit bit counter wraps from 7 to exit.
- STOP: tx=1 for CLKS_PER_BIT cycles. Then:
  - if byte_idx==MSG_LEN-1, go to DONE;
  - else byte_idx+=1 and go to FETCH.
- DONE: done=1 for exactly 1 cycle, busy=1 in that cycle, then IDLE.
- Timing:
  - Per-byte time: 2 + 10*CLKS_PER_BIT cycles.
  - Total from start acceptance to done pulse: MSG_LEN*(2+10*CLKS_PER_BIT)+1 cycles.
- Baud counter: 16-bit, counts 0..CLKS_PER_BIT-1 and clears on every bit boundary and on state entry.
- start held high or re-asserted while busy is ignored. start high in the cycle DONE returns to IDLE is accepted on the next IDLE cycle; transmission restarts from byte 0.
- mem_address is held stable through READ and all bit states of a byte.
- The byte value is not interpreted: 0x00 and 0xFF are transmitted as-is.

Optional Feature:
- Macro: RC4_MSG_TX_CRLF_EN.
- When defined: after byte MSG_LEN-1, the block sends two extra frames, 0x0D then 0x0A, using the same START/DATA/STOP timing without RAM access. There is no FETCH/READ for these frames; 10*CLKS_PER_BIT cycles each. DONE follows the 0x0A stop bit.
- When undefined: DONE follows the last message byte; no trailer logic is synthesized.

Decomposition:
- Package rc4_pkg:
  - tx state enum;
  - MSG_LEN_DEFAULT=32;
  - ASCII_CR=8'h0D and ASCII_LF=8'h0A.
- One sub-module: uart_tx_byte.
  - Serializer with START/DATA/STOP and the baud counter.
  - Interface: load pulse + 8-bit data in; tx and frame_done out.
- rc4_msg_uart_tx keeps the RAM fetch sequencing, byte indexing and the optional CRLF trailer.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with start=1 -> tx=1, busy=0, done=0, mem_address=0 throughout.
- Single message:
  - Setup: CLKS_PER_BIT=4, MSG_LEN=32, RAM model with 1-cycle latency preloaded with "abcd..." (0x61 upward).
  - Stimulus: pulse start.
  - Required response: the line decoder captures 32 bytes 0x61..0x80 in order, each framed as start=0 and stop=1. done pulses once at cycle 32*42+1 after acceptance.
- Bit order: RAM[0]=0xA5 with CLKS_PER_BIT=4 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles.
- Start while busy: re-pulse start at byte_idx=5 -> no restart; byte_idx continues 6,7,... and exactly one done pulse.
- Mid-frame reset: assert reset_n=0 during DATA of byte 3 -> tx=1 and busy=0 next edge. A new start resends from byte 0.
- With RC4_MSG_TX_CRLF_EN and MSG_LEN=2, RAM={0x48,0x49} -> received 0x48,0x49,0x0D,0x0A. done occurs after the 0x0A stop bit; mem_address never exceeds 1.
